// File: rtl/opl_timer_pkg.sv
// Shared constants for the OPL timer bank: register indices, control/status
// bit positions and the per-timer resolution helper.
package opl_timer_pkg;

  localparam logic [7:0] REG_TEST        = 8'd1;
  localparam logic [7:0] REG_PRESET_BASE = 8'd2;
  localparam logic [7:0] REG_CTRL        = 8'd4;

  localparam int CTRL_IRQ_RST    = 7;
  localparam int CTRL_MASK_BASE  = 6;
  localparam int CTRL_START_BASE = 0;

  localparam int STAT_IRQ        = 7;
  localparam int STAT_FLAG_BASE  = 6;

  // Timer i counts in steps of base << 2i ticks (80 us, 320 us, 1280 us).
  function automatic int unsigned timer_res(input int unsigned base_us, input int unsigned idx);
    return base_us << (2 * idx);
  endfunction

endpackage

// File: rtl/opl_timer_bank_if.sv
// Host-side index/data port of the timer bank, shared with the FM core decode.
interface opl_timer_bank_if;
  logic       addr;
  logic [7:0] din;
  logic       wr;
  logic [7:0] dout;
  logic       irq_n;

  // wr is a level strobe with no ready: the bank takes exactly one write on
  // each low-to-high transition and never stalls; addr/din must be stable
  // on the cycle wr first goes high. dout/irq_n are always valid.
  modport master (output addr, din, wr, input dout, irq_n);
  modport slave  (input addr, din, wr, output dout, irq_n);
endinterface

// File: rtl/opl_timer_chan.sv
// One interval timer: prescaler (sub) plus up-counter (cnt), reloading from
// the preset on wrap and pulsing ovf_o on the wrapping tick.
module opl_timer_chan #(
  parameter int CNT_W = 8,
  parameter int RES   = 80
) (
  input  logic             clk_opl,
  input  logic             rst_n,
  input  logic             ce_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] preset_i,
  output logic             ovf_o
);
  localparam int SUB_W = (RES > 1) ? $clog2(RES) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(RES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0] sub_q, sub_d;

  always_comb begin
    cnt_d = cnt_q;
    sub_d = sub_q;
    ovf_o = 1'b0;
    // Stopped timers shadow the preset so a later start begins from it.
    if (!start_i) begin
      cnt_d = preset_i;
      sub_d = SUB_MAX;
    end else if (ce_i) begin
      if (sub_q != '0) begin
        sub_d = sub_q - 1'b1;
      end else begin
        sub_d = SUB_MAX;
        if (&cnt_q) begin
          cnt_d = preset_i;
          ovf_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_opl) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sub_q <= SUB_MAX;
    end else begin
      cnt_q <= cnt_d;
      sub_q <= sub_d;
    end
  end

endmodule

// File: rtl/opl_timer_bank.sv
// OPL-compatible timer bank: 1 us tick, index/data register decode, flags,
// status byte and IRQ. Optional test register enabled by OPL_TIMER_FORCE_EN.
module opl_timer_bank
  import opl_timer_pkg::*;
#(
  parameter int N_TIMERS    = 2,
  parameter int CNT_W       = 8,
  parameter int CLK_DIV     = 14,
  parameter int RES_BASE_US = 80
) (
  input logic               clk_opl,
  input logic               rst_n,
  opl_timer_bank_if.slave   bus
);
  localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLK_DIV - 1);

  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                wr_q;
  logic [7:0]          index_q, index_d;
  logic [CNT_W-1:0]    preset_q [N_TIMERS];
  logic [CNT_W-1:0]    preset_d [N_TIMERS];
  logic [N_TIMERS-1:0] start_q, start_d;
  logic [N_TIMERS-1:0] mask_q, mask_d;
  logic [N_TIMERS-1:0] flag_q, flag_d;
  logic [N_TIMERS-1:0] ovf;
  logic [N_TIMERS-1:0] force_set;
  logic                ce, wr_ev, idx_wr, data_wr, ctrl_wr;

  assign ce      = (tick_q == TICK_MAX);
  assign wr_ev   = bus.wr & ~wr_q;
  assign idx_wr  = wr_ev & ~bus.addr;
  assign data_wr = wr_ev & bus.addr;
  assign ctrl_wr = data_wr && (index_q == REG_CTRL);

`ifdef OPL_TIMER_FORCE_EN
  assign force_set = (data_wr && (index_q == REG_TEST) && bus.din[2]) ? ~mask_q : '0;
`else
  assign force_set = '0;
`endif

  always_comb begin
    tick_d   = ce ? '0 : tick_q + 1'b1;
    index_d  = idx_wr ? bus.din : index_q;
    preset_d = preset_q;
    start_d  = start_q;
    mask_d   = mask_q;
    for (int i = 0; i < N_TIMERS; i++) begin
      if (data_wr && (index_q == 8'(int'(REG_PRESET_BASE) + i)))
        preset_d[i] = bus.din[CNT_W-1:0];
    end
    if (ctrl_wr && !bus.din[CTRL_IRQ_RST]) begin
      for (int i = 0; i < N_TIMERS; i++) begin
        start_d[i] = bus.din[CTRL_START_BASE + i];
        mask_d[i]  = bus.din[CTRL_MASK_BASE - i];
      end
    end
    // Any control write clears; a same-cycle overflow or force still sets.
    flag_d = (flag_q & ~{N_TIMERS{ctrl_wr}}) | (ovf & ~mask_q) | force_set;
  end

  always_ff @(posedge clk_opl) begin
    if (!rst_n) begin
      tick_q  <= '0;
      wr_q    <= 1'b0;
      index_q <= '0;
      for (int i = 0; i < N_TIMERS; i++) preset_q[i] <= '0;
      start_q <= '0;
      mask_q  <= '0;
      flag_q  <= '0;
    end else begin
      tick_q   <= tick_d;
      wr_q     <= bus.wr;
      index_q  <= index_d;
      preset_q <= preset_d;
      start_q  <= start_d;
      mask_q   <= mask_d;
      flag_q   <= flag_d;
    end
  end

  for (genvar g = 0; g < N_TIMERS; g++) begin : g_chan
    opl_timer_chan #(
      .CNT_W (CNT_W),
      .RES   (int'(timer_res(RES_BASE_US, g)))
    ) u_chan (
      .clk_opl  (clk_opl),
      .rst_n    (rst_n),
      .ce_i     (ce),
      .start_i  (start_q[g]),
      .preset_i (preset_q[g]),
      .ovf_o    (ovf[g])
    );
  end

  always_comb begin
    bus.dout = '0;
    bus.dout[STAT_IRQ] = |flag_q;
    for (int i = 0; i < N_TIMERS; i++) bus.dout[STAT_FLAG_BASE - i] = flag_q[i];
  end

  assign bus.irq_n = ~(|flag_q);

endmodule

// File: tb/tb_opl_timer_bank.sv
// Bench for opl_timer_bank at default parameters (14 clk per tick, 80/320 us).
module tb_opl_timer_bank;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   t_wr = 0;
  int   ovf_cnt = 0;

  opl_timer_bank_if bus();

  opl_timer_bank dut (
    .clk_opl (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (dut.g_chan[0].u_chan.ovf_o) ovf_cnt++;

  // ---------------- vector table ----------------
  typedef struct {
    logic       a;
    logic [7:0] d;
    logic [7:0] exp_dout;
    logic       exp_irq_n;
  } vec_t;

  vec_t vecs[14];

`ifdef OPL_TIMER_FORCE_EN
  localparam logic [7:0] EXP_FALL = 8'hE0;
  localparam logic [7:0] EXP_F0   = 8'hC0;
  localparam logic       EXP_FIRQ = 1'b0;
`else
  localparam logic [7:0] EXP_FALL = 8'h00;
  localparam logic [7:0] EXP_F0   = 8'h00;
  localparam logic       EXP_FIRQ = 1'b1;
`endif

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wr_reg(input logic a, input logic [7:0] d);
    @(negedge clk);
    bus.addr = a;
    bus.din  = d;
    bus.wr   = 1'b1;
    @(negedge clk);
    bus.wr   = 1'b0;
    t_wr     = cyc;
  endtask

  task automatic wait_flag(input int max, output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (bus.dout != 8'h00) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic quiet_run(input int n, output int busy);
    busy = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.dout != 8'h00 || bus.irq_n !== 1'b1) busy++;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int c1, c2, t0, busy;
    bit ok;

    vecs[0]  = '{1'b0, 8'h02, 8'h00, 1'b1};
    vecs[1]  = '{1'b1, 8'hFF, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, 8'h05, 8'h00, 1'b1};
    vecs[3]  = '{1'b1, 8'hAA, 8'h00, 1'b1};
    vecs[4]  = '{1'b0, 8'h01, 8'h00, 1'b1};
    vecs[5]  = '{1'b1, 8'h04, EXP_FALL, EXP_FIRQ};
    vecs[6]  = '{1'b0, 8'h04, EXP_FALL, EXP_FIRQ};
    vecs[7]  = '{1'b1, 8'h80, 8'h00, 1'b1};
    vecs[8]  = '{1'b1, 8'h20, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 8'h01, 8'h00, 1'b1};
    vecs[10] = '{1'b1, 8'h04, EXP_F0, EXP_FIRQ};
    vecs[11] = '{1'b1, 8'h00, EXP_F0, EXP_FIRQ};
    vecs[12] = '{1'b0, 8'h04, EXP_F0, EXP_FIRQ};
    vecs[13] = '{1'b1, 8'h00, 8'h00, 1'b1};

    rst_n    = 1'b0;
    bus.addr = 1'b0;
    bus.din  = 8'h00;
    bus.wr   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout", bus.dout, 8'h00);
    check("reset_irq_n", bus.irq_n, 1'b1);
    rst_n = 1'b1;

    quiet_run(5000, busy);
    check("idle_no_flag", busy, 0);

    for (int i = 0; i < 14; i++) begin
      wr_reg(vecs[i].a, vecs[i].d);
      check($sformatf("vec%0d_dout", i), bus.dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_irq_n", i), bus.irq_n, vecs[i].exp_irq_n);
    end

    // Timer 0, preset FF: 80 ticks to overflow, then every 80 ticks.
    wr_reg(1'b0, 8'h02); wr_reg(1'b1, 8'hFF);
    wr_reg(1'b0, 8'h04); wr_reg(1'b1, 8'h01);
    t0 = t_wr;
    wait_flag(1300, c1, ok);
    check("t0_flag_seen", ok, 1'b1);
    check_range("t0_latency", c1 - t0, 1107, 1133);
    check("t0_dout", bus.dout, 8'hC0);
    check("t0_irq_n", bus.irq_n, 1'b0);
    wr_reg(1'b1, 8'h80);
    check("t0_clear", bus.dout, 8'h00);
    wait_flag(1300, c2, ok);
    check("t0_reflag_seen", ok, 1'b1);
    check("t0_period", c2 - c1, 1120);

    // Clear lands on the same edge as the next overflow: set must win.
    wait_cyc(c2 + 1119);
    bus.addr = 1'b1; bus.din = 8'h80; bus.wr = 1'b1;
    @(negedge clk);
    bus.wr = 1'b0;
    check("clear_vs_ovf", bus.dout, 8'hC0);

    // Held wr spanning an overflow: only the leading edge may clear.
    wr_reg(1'b1, 8'h80);
    check("pre_hold_clear", bus.dout, 8'h00);
    wait_cyc(c2 + 2236);
    bus.addr = 1'b1; bus.din = 8'h80; bus.wr = 1'b1;
    repeat (10) @(negedge clk);
    bus.wr = 1'b0;
    check("held_wr_one_write", bus.dout, 8'hC0);

    // Reset mid-count drops the flag and the running timer.
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_dout", bus.dout, 8'h00);
    check("midrst_irq_n", bus.irq_n, 1'b1);
    rst_n = 1'b1;
    quiet_run(1300, busy);
    check("post_rst_quiet", busy, 0);

    // Timer 1, preset FE: 2 x 320 = 640 ticks.
    wr_reg(1'b0, 8'h03); wr_reg(1'b1, 8'hFE);
    wr_reg(1'b0, 8'h04); wr_reg(1'b1, 8'h02);
    t0 = t_wr;
    wait_flag(9100, c1, ok);
    check("t1_flag_seen", ok, 1'b1);
    check_range("t1_latency", c1 - t0, 8947, 8973);
    check("t1_dout", bus.dout, 8'hA0);
    check("t1_irq_n", bus.irq_n, 1'b0);
    wr_reg(1'b1, 8'h80);
    check("t1_clear_dout", bus.dout, 8'h00);
    check("t1_clear_irq_n", bus.irq_n, 1'b1);
    wait_flag(9100, c2, ok);
    check("t1_reflag_seen", ok, 1'b1);
    check("t1_period", c2 - c1, 8960);

    // Timer 0 masked: counter wraps, no flag ever raised.
    wr_reg(1'b1, 8'h00);
    check("stop_all", bus.dout, 8'h00);
    wr_reg(1'b0, 8'h02); wr_reg(1'b1, 8'hFF);
    wr_reg(1'b0, 8'h04);
    ovf_cnt = 0;
    wr_reg(1'b1, 8'h41);
    quiet_run(14000, busy);
    check("masked_no_flag", busy, 0);
    check("masked_ovf_count", ovf_cnt, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
